// File: rtl/sonic_rx_st_pkg.sv
// rtl/sonic_rx_st_pkg.sv - shared constants, framing states and lane helpers for the RX lane adapter
package sonic_rx_st_pkg;

    localparam int LANE_DATA_W = 64;
    localparam int LANE_BE_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_t;

    // One bit of the lane-valid mask: every lane is live on non-eop beats,
    // on the eop beat only lanes below the empty tail are live.
    function automatic logic lane_valid(input int lane, input int lanes,
                                        input logic eop, input int empty);
        return !eop || (lane <= lanes - 1 - empty);
    endfunction

endpackage

// File: rtl/sonic_fwft_fifo.sv
// rtl/sonic_fwft_fifo.sv - first-word-fall-through FIFO with occupancy count
module sonic_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      used,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (used == (AW+1)'(DEPTH));
    assign empty   = (used == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // Storage array; contents need no reset because used gates visibility.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sonic_rx_st_lane_adapter.sv
// rtl/sonic_rx_st_lane_adapter.sv - Avalon-ST RX beat to per-lane application stream converter
module sonic_rx_st_lane_adapter
    import sonic_rx_st_pkg::*;
#(
    parameter int DATA_W        = 128,
    parameter int BAR_W         = 8,
    parameter int EMPTY_W       = 1,
    parameter int READY_LATENCY = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int DROP_ERR      = 1
) (
    input  logic                                clk_in,
    input  logic                                rst,
    input  logic [DATA_W-1:0]                   rx_st_data,
    input  logic [DATA_W/8-1:0]                 rx_st_be,
    input  logic [BAR_W-1:0]                    rx_st_bardec,
    input  logic                                rx_st_sop,
    input  logic                                rx_st_eop,
    input  logic [EMPTY_W-1:0]                  rx_st_empty,
    input  logic                                rx_st_err,
    input  logic                                rx_st_valid,
    output logic                                rx_st_ready,
    input  logic                                rx_stream_mask,
    output logic [(DATA_W/64)*(74+BAR_W)-1:0]   out_data,
    output logic [DATA_W/64-1:0]                out_lane_valid,
    output logic                                out_err,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         pkt_cnt,
    output logic [15:0]                         err_pkt_cnt,
    output logic [15:0]                         frame_err_cnt,
    output logic                                proto_err
);

    localparam int LANES   = DATA_W / 64;
    localparam int LANE_W  = LANE_BE_W + 2 + BAR_W + LANE_DATA_W;
    localparam int WORDS_W = LANES * LANE_W;
    localparam int ENTRY_W = WORDS_W + LANES + 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PIPE_W  = (READY_LATENCY == 0) ? 1 : READY_LATENCY;

    logic [PIPE_W-1:0]  rdy_pipe;
    logic [31:0]        inflight;
    logic               window;
    logic               sample;
    logic               drop_sop;
    logic [AW:0]        used;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [WORDS_W-1:0] lane_words;
    logic [LANES-1:0]   lane_mask;
    state_t             state;
    state_t             state_nxt;
    logic               wr_en;
    logic               inc_pkt;
    logic               inc_err;
    logic               inc_frame;

    // Credits already promised to the hard IP but not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_W; i++) inflight = inflight + 32'(rdy_pipe[i]);
    end

    assign rx_st_ready = !rst && !rx_stream_mask &&
                         (32'(used) + inflight + 32'd1 <= 32'(FIFO_DEPTH));
    assign window      = (READY_LATENCY == 0) ? rx_st_ready : rdy_pipe[PIPE_W-1];
    assign sample      = rx_st_valid && window;
    assign drop_sop    = rx_st_err && (DROP_ERR != 0);

    // Delay line of issued readies; its last tap opens the sampling window.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                     rdy_pipe <= '0;
        else if (READY_LATENCY == 0) rdy_pipe <= '0;
        else                         rdy_pipe <= (rdy_pipe << 1) | PIPE_W'(rx_st_ready);
    end

    // Framing decisions for a sampled beat: write, drop, and which counter moves.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        inc_pkt   = 1'b0;
        inc_err   = 1'b0;
        inc_frame = 1'b0;
        if (sample) begin
            case (state)
                IN_PKT: begin
                    wr_en     = 1'b1;
                    inc_frame = rx_st_sop;
                    if (rx_st_eop) begin
                        inc_pkt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                IDLE, DROP: begin
                    if (rx_st_sop) begin
                        inc_frame = (state == DROP);
                        if (!drop_sop) begin
                            wr_en     = 1'b1;
                            inc_pkt   = rx_st_eop;
                            state_nxt = rx_st_eop ? IDLE : IN_PKT;
                        end else begin
                            inc_err   = rx_st_eop;
                            state_nxt = rx_st_eop ? IDLE : DROP;
                        end
                    end else if (state == DROP) begin
                        if (rx_st_eop) begin
                            inc_err   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        inc_frame = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Framing state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Saturating statistics and the sticky protocol-violation flag.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pkt_cnt       <= '0;
            err_pkt_cnt   <= '0;
            frame_err_cnt <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (inc_pkt && pkt_cnt != '1)         pkt_cnt       <= pkt_cnt + 32'd1;
            if (inc_err && err_pkt_cnt != '1)     err_pkt_cnt   <= err_pkt_cnt + 16'd1;
            if (inc_frame && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 16'd1;
            if ((rx_st_valid && !window) || (wr_en && fifo_full)) proto_err <= 1'b1;
        end
    end

    // Slice the beat into lane words {be, sop, last, bardec, data} plus the live-lane mask.
    always_comb begin
        int last_idx;
        last_idx   = LANES - 1 - int'(rx_st_empty);
        lane_words = '0;
        lane_mask  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_words[i*LANE_W +: LANE_W] = {rx_st_be[i*LANE_BE_W +: LANE_BE_W],
                                              rx_st_sop,
                                              rx_st_eop && (i == last_idx),
                                              rx_st_bardec,
                                              rx_st_data[i*LANE_DATA_W +: LANE_DATA_W]};
            lane_mask[i] = lane_valid(i, LANES, rx_st_eop, int'(rx_st_empty));
        end
    end

    sonic_fwft_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst     (rst),
        .push    (wr_en),
        .wr_data ({rx_st_err, lane_mask, lane_words}),
        .pop     (out_ready),
        .rd_data (head),
        .used    (used),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid      = !fifo_empty;
    assign out_data       = head[WORDS_W-1:0];
    assign out_lane_valid = out_valid ? head[WORDS_W +: LANES] : '0;
    assign out_err        = out_valid && head[ENTRY_W-1];

endmodule
